// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Turns a toggle-encoded event line (one level change per event) into a queue of discrete
//   events. The consumer takes them one at a time through a valid/ready handshake.
//
//   Optional feature macro: TOGGLE_SYNC_EN
//     When defined, tog_in passes through a two-flop synchronizer before s0, so tog_in may be
//     asynchronous to clk. Event latency becomes 4 cycles instead of 2.
//
//   Parameters
//     CW        pending-counter width; the queue holds at most 2^CW-1 events
//     TW        total-event-counter width
//   Ports
//     clk       clock, rising edge
//     rst_n     asynchronous active-low reset
//     en        sampling enable; transitions detected while low are discarded
//     tog_in    toggle-encoded event line
//     ev_ready  consumer accepts one event this cycle
//     clr_ovf   clears the sticky overflow flag (a simultaneous drop wins)
//     ev_valid  at least one event is pending
//     pend_cnt  number of pending events
//     total_cnt detected transitions, modulo 2^TW
//     ovf       sticky: an event was dropped because the queue was full
module toggle_event_decoder #(
   parameter int unsigned CW = 4,
   parameter int unsigned TW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          tog_in,
   input  logic          ev_ready,
   input  logic          clr_ovf,
   output logic          ev_valid,
   output logic [CW-1:0] pend_cnt,
   output logic [TW-1:0] total_cnt,
   output logic          ovf
);

   // Encoding chosen so that ev_valid is a direct copy of state_q[0].
   localparam logic [1:0] StIdle = 2'b00;
   localparam logic [1:0] StPend = 2'b01;
   localparam logic [1:0] StFull = 2'b11;

   localparam logic [CW-1:0] CntMax = {CW{1'b1}};

   logic          s0_q, d0_q, armed_q;
   logic          s0_d, armed_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] pend_q, pend_d;
   logic [TW-1:0] total_q, total_d;
   logic          ovf_q, ovf_d;
   logic          edge_det, pop, drop;

`ifdef TOGGLE_SYNC_EN
   logic       sync1_q, sync2_q;
   logic [1:0] arm_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         arm_cnt_q <= 2'd0;
      end else begin
         sync1_q <= tog_in;
         sync2_q <= sync1_q;
         if (arm_cnt_q != 2'd2) begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
         end
      end
   end

   assign s0_d    = sync2_q;
   // Arms on the third clock after release, once the synchronizer holds real input.
   assign armed_d = armed_q | (arm_cnt_q == 2'd2);
`else
   assign s0_d    = tog_in;
   assign armed_d = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q    <= 1'b0;
         d0_q    <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         s0_q    <= s0_d;
         // Until armed, d0 tracks the value s0 is loading so the first armed compare sees
         // no difference: a level already high at reset release is not an event.
         d0_q    <= armed_q ? s0_q : s0_d;
         armed_q <= armed_d;
      end
   end

   assign edge_det = armed_q & en & (s0_q ^ d0_q);
   assign pop      = ev_valid & ev_ready;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      drop    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (edge_det) begin
               pend_d  = pend_q + CW'(1);
               state_d = (pend_d == CntMax) ? StFull : StPend;
            end
         end
         StPend: begin
            if (edge_det && !pop) begin
               pend_d  = pend_q + CW'(1);
               state_d = (pend_d == CntMax) ? StFull : StPend;
            end else if (pop && !edge_det) begin
               pend_d  = pend_q - CW'(1);
               state_d = (pend_d == '0) ? StIdle : StPend;
            end
         end
         StFull: begin
            if (pop && !edge_det) begin
               pend_d  = pend_q - CW'(1);
               state_d = (pend_d == '0) ? StIdle : StPend;
            end else if (edge_det && !pop) begin
               drop = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            pend_d  = '0;
         end
      endcase
   end

   always_comb begin
      total_d = edge_det ? total_q + TW'(1) : total_q;
      ovf_d   = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pend_q  <= '0;
         total_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         total_q <= total_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ev_valid  = state_q[0];
   assign pend_cnt  = pend_q;
   assign total_cnt = total_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder (CW=4, TW=16).
module tb_toggle_event_decoder;

`ifdef TOGGLE_SYNC_EN
   localparam int Lat = 4;
`else
   localparam int Lat = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        tog_in;
   logic        ev_ready;
   logic        clr_ovf;
   logic        ev_valid;
   logic [3:0]  pend_cnt;
   logic [15:0] total_cnt;
   logic        ovf;

   int n_pass  = 0;
   int n_total = 0;

   toggle_event_decoder #(.CW(4), .TW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .tog_in   (tog_in),
      .ev_ready (ev_ready),
      .clr_ovf  (clr_ovf),
      .ev_valid (ev_valid),
      .pend_cnt (pend_cnt),
      .total_cnt(total_cnt),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle();
      tog_in = ~tog_in;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input int p, input int t, input int v, input int o);
      check({tag, ".pend"}, 32'(pend_cnt), p);
      check({tag, ".total"}, 32'(total_cnt), t);
      check({tag, ".valid"}, 32'(ev_valid), v);
      check({tag, ".ovf"}, 32'(ovf), o);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      tog_in   = 1'b1;
      ev_ready = 1'b0;
      clr_ovf  = 1'b0;
      #2;
      check_all("reset", 0, 0, 0, 0);

      // High tog_in at release is not an event.
      tick(2);
      rst_n = 1'b1;
      tick(10);
      check_all("release_high", 0, 0, 0, 0);

      // Event latency on the first toggle.
      toggle();
      tick(Lat - 1);
      check("lat_before", 32'(pend_cnt), 0);
      tick(1);
      check("lat_at", 32'(pend_cnt), 1);
      check("lat_valid", 32'(ev_valid), 1);
      tick(1);
      toggle();
      tick(2);
      toggle();
      tick(Lat + 1);
      check_all("three_events", 3, 3, 1, 0);

      // Three back-to-back pops.
      ev_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("pop_valid", 32'(ev_valid), 1);
         check("pop_pend", 32'(pend_cnt), 3 - i);
         tick(1);
      end
      ev_ready = 1'b0;
      check_all("drained", 0, 3, 0, 0);

      // 17 toggles: 15 queued, 2 dropped.
      for (int i = 0; i < 17; i++) begin
         toggle();
         tick(1);
      end
      tick(Lat + 1);
      check_all("overflow", 15, 20, 1, 1);

      // Drop and clear in the same cycle: set wins.
      toggle();
      tick(Lat - 1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check_all("set_wins", 15, 21, 1, 1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("clr_ovf", 32'(ovf), 0);

      // FULL: edge and pop together leave the count alone and do not drop.
      toggle();
      tick(Lat - 1);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      check_all("full_edge_pop", 15, 22, 1, 0);

      ev_ready = 1'b1;
      tick(10);
      ev_ready = 1'b0;
      check("drain_to_5", 32'(pend_cnt), 5);

      // PEND: edge and pop together leave the count alone.
      toggle();
      tick(Lat - 1);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      check_all("pend_edge_pop", 5, 23, 1, 0);

      // Transition while disabled is lost, not deferred.
      en = 1'b0;
      toggle();
      tick(Lat + 2);
      en = 1'b1;
      tick(Lat + 2);
      check_all("en_low", 5, 23, 1, 0);

      // Asynchronous reset mid-burst.
      toggle();
      tick(2);
      toggle();
      tick(Lat + 1);
      check("pend_7", 32'(pend_cnt), 7);
      toggle();
      tick(1);
      toggle();
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 0, 0, 0, 0);
      tick(2);
      check_all("held_reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick(5);
      check_all("after_reset", 0, 0, 0, 0);

      // Total counter wrap.
      for (int i = 0; i < 65535; i++) begin
         toggle();
         tick(1);
      end
      tick(Lat + 1);
      check_all("total_max", 15, 32'hFFFF, 1, 1);
      toggle();
      tick(Lat + 1);
      check("total_wrap", 32'(total_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
